hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the single-cycle load-use interlock for the 5-stage core.
- Adds a per-register scoreboard of in-flight loads, so data memories with LOAD_LAT > 1 cycles are interlocked correctly.
- Adds a global freeze when data memory is not ready, flush masking, and a saturating stall-cycle performance counter.
- Sits beside the IF/ID and ID/EX pipeline registers. Drives PC/IF-ID hold, ID/EX bubble and whole-pipe freeze.

Parameters:
- REGW, 5, register index width.
- NREG, 32, number of architectural registers; must equal 2**REGW.
- LOAD_LAT, 1, stall cycles a directly dependent instruction incurs after a load; must be ≥ 1.
- PERF_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- IFrs1  in  REGW  rs1 of the instruction being decoded (IF/ID register).
- IFrs2  in  REGW  rs2 of the instruction being decoded.
- IFuseRs1  in  1  decoded instruction actually reads rs1.
- IFuseRs2  in  1  decoded instruction actually reads rs2.
- IDrd  in  REGW  rd of the instruction in ID/EX.
- IDmemRead  in  1  ID/EX instruction is a load.
- IDvalid  in  1  ID/EX holds a valid (non-bubble) instruction.
- mem_ready  in  1  data memory can accept/complete this cycle.
- flush  in  1  control-flow redirect; the decode-stage instruction is squashed this cycle.
- stall  out  1  hold PC and IF/ID, insert bubble into ID/EX.
- freeze  out  1  hold every pipeline register.
- busy_any  out  1  at least one register has a nonzero scoreboard count.
- stall_count  out  PERF_W  saturating count of stall cycles.

Behaviour:
- State: cnt[r], width clog2(LOAD_LAT), one per register r = 1..NREG-1. r = 0 is never tracked and reads as 0. When LOAD_LAT = 1 the cnt array degenerates to constant 0.
- Plus stall_count.
- Reset (rst = 1 at an edge): all cnt ← 0, stall_count ← 0.
- While rst = 1, stall = 0, freeze = 0, busy_any = 0 combinationally.
- freeze = !mem_ready (combinational).
- hit_id = IDvalid && IDmemRead && IDrd != 0 && ((IFuseRs1 && IDrd == IFrs1) || (IFuseRs2 && IDrd == IFrs2)).
- hit_sb = (IFuseRs1 && IFrs1 != 0 && cnt[IFrs1] != 0) || (IFuseRs2 && IFrs2 != 0 && cnt[IFrs2] != 0).
- stall = (hit_id || hit_sb) && !flush && !rst. Combinational, zero latency.
- A flushed decode instruction never stalls.
- Issue: when freeze = 0, IDvalid && IDmemRead && IDrd != 0, then cnt[IDrd] ← LOAD_LAT-1 at the edge.
- Countdown: when freeze = 0, every other nonzero cnt decrements by 1 per edge.
- Issue to a register whose cnt is already nonzero overwrites it with LOAD_LAT-1; the newest load wins and there is no decrement that cycle.
- freeze = 1: no cnt changes, no issue, stall_count holds. stall still reflects the current hits.
- Resulting timing: a dependent instruction immediately behind a load stalls exactly LOAD_LAT cycles (1 from hit_id, LOAD_LAT-1 from hit_sb), excluding freeze cycles.
- A dependent instruction k cycles behind stalls max(0, LOAD_LAT-k) cycles.
- flush does not clear cnt: loads older than the redirect still complete.
- busy_any = OR of all cnt != 0 (registered state only).
- stall_count increments by 1 on each edge where stall = 1, freeze = 0 and rst = 0. It saturates at all-ones and never wraps.
- Reset mid-operation clears all pending counts. Upstream is required to flush the pipeline on the same reset.

Test Plan:
- LOAD_LAT=1, load x5 in ID/EX, decode reads rs1 = x5 → stall = 1 for exactly 1 cycle, stall_count = 1, busy_any stays 0.
- LOAD_LAT=3, load x7, dependent immediately behind → stall high 3 consecutive cycles. cnt[7] goes 2, 1, 0. stall_count = 3.
- LOAD_LAT=3, load x7, one independent instruction, then reader of x7 → stall for 2 cycles. Reader of x7 with IFuseRs1 = 0 → no stall.
- Load to x0, decode reads x0 → no stall ever. Two loads to x9 on back-to-back issue cycles → cnt[9] reloads to LOAD_LAT-1 on the second.
- LOAD_LAT=3, mem_ready=0 for 4 cycles mid-stall → freeze = 1, cnt and stall_count frozen. Total stall cycles after release is still 3.
- flush = 1 during a hit → stall = 0 and cnt untouched. stall_count preset near max (PERF_W = 4, value 15) → holds at 15. rst mid-countdown → all cnt 0, busy_any = 0 next cycle.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// Decode/execute hazard signals shared between the pipeline control and the load-use scoreboard.
interface hazard_scoreboard_if #(
    parameter int REGW   = 5,
    parameter int PERF_W = 32
);
    logic [REGW-1:0]   IFrs1;
    logic [REGW-1:0]   IFrs2;
    logic              IFuseRs1;
    logic              IFuseRs2;
    logic [REGW-1:0]   IDrd;
    logic              IDmemRead;
    logic              IDvalid;
    logic              mem_ready;
    logic              flush;
    logic              stall;
    logic              freeze;
    logic              busy_any;
    logic [PERF_W-1:0] stall_count;

    modport master (
        output IFrs1, IFrs2, IFuseRs1, IFuseRs2, IDrd, IDmemRead, IDvalid, mem_ready, flush,
        input  stall, freeze, busy_any, stall_count
    );

    modport slave (
        input  IFrs1, IFrs2, IFuseRs1, IFuseRs2, IDrd, IDmemRead, IDvalid, mem_ready, flush,
        output stall, freeze, busy_any, stall_count
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Load-use interlock with a per-register countdown of in-flight loads, memory freeze,
// flush masking and a saturating stall-cycle counter.
module hazard_scoreboard #(
    parameter int REGW     = 5,
    parameter int NREG     = 32,
    parameter int LOAD_LAT = 1,
    parameter int PERF_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    hazard_scoreboard_if.slave hz
);
    // With LOAD_LAT = 1 every count is reloaded with 0, so the array is effectively constant.
    localparam int CW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(LOAD_LAT - 1);

    logic [CW-1:0]     cnt_q [NREG];
    logic [CW-1:0]     cnt_d [NREG];
    logic [PERF_W-1:0] stall_count_q;
    logic [PERF_W-1:0] stall_count_d;
    logic              hit_id_s;
    logic              hit_sb_s;
    logic              stall_s;
    logic              freeze_s;
    logic              issue_s;
    logic              busy_s;

    // Hazard detection against the ID/EX load and against older loads still in flight.
    always_comb begin
        issue_s  = hz.IDvalid && hz.IDmemRead && (hz.IDrd != '0);
        hit_id_s = issue_s && ((hz.IFuseRs1 && (hz.IDrd == hz.IFrs1)) ||
                               (hz.IFuseRs2 && (hz.IDrd == hz.IFrs2)));
        hit_sb_s = (hz.IFuseRs1 && (hz.IFrs1 != '0) && (cnt_q[hz.IFrs1] != '0)) ||
                   (hz.IFuseRs2 && (hz.IFrs2 != '0) && (cnt_q[hz.IFrs2] != '0));
        freeze_s = !hz.mem_ready;
        stall_s  = (hit_id_s || hit_sb_s) && !hz.flush && !rst;
    end

    // Scoreboard next state: a new load to a register overrides its countdown.
    always_comb begin
        busy_s   = 1'b0;
        cnt_d[0] = '0;
        for (int r = 1; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            if (freeze_s) begin
                cnt_d[r] = cnt_q[r];
            end else if (issue_s && (hz.IDrd == REGW'(r))) begin
                cnt_d[r] = RELOAD;
            end else if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - CW'(1);
            end else begin
                cnt_d[r] = cnt_q[r];
            end
            busy_s = busy_s || (cnt_q[r] != '0);
        end
    end

    // Stall-cycle counter next state, saturating at all-ones.
    always_comb begin
        stall_count_d = stall_count_q;
        if (stall_s && !freeze_s && !(&stall_count_q)) begin
            stall_count_d = stall_count_q + PERF_W'(1);
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            stall_count_q <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            stall_count_q <= stall_count_d;
        end
    end

    assign hz.stall       = stall_s;
    assign hz.freeze      = freeze_s && !rst;
    assign hz.busy_any    = busy_s && !rst;
    assign hz.stall_count = stall_count_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Random and directed stimulus for two scoreboard configurations, checked against a
// ready-time reference model of the interlock rules.
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REGW(5), .PERF_W(32)) hz1 ();
    hazard_scoreboard_if #(.REGW(5), .PERF_W(4))  hz3 ();

    hazard_scoreboard #(.REGW(5), .NREG(32), .LOAD_LAT(1), .PERF_W(32)) u_l1 (
        .clk(clk), .rst(rst), .hz(hz1.slave));
    hazard_scoreboard #(.REGW(5), .NREG(32), .LOAD_LAT(3), .PERF_W(4)) u_l3 (
        .clk(clk), .rst(rst), .hz(hz3.slave));

    int checks   = 0;
    int failures = 0;

    // Reference state: each register becomes free once the unfrozen-edge tick reaches ready_at.
    longint tick;
    longint ready_at [2][32];
    longint scount   [2];
    int     lat      [2] = '{1, 3};
    longint smax     [2] = '{64'hFFFF_FFFF, 64'd15};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic pending(input int i, input logic [4:0] r);
        return (r != 5'd0) && (ready_at[i][r] > tick);
    endfunction

    task automatic cyc(input logic r_rst, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic mrd, input logic idv, input logic mrdy, input logic fl);
        logic hit_id;
        logic exp_stall [2];
        logic exp_busy;
        rst = r_rst;
        hz1.IFrs1 = rs1;  hz1.IFrs2 = rs2;  hz1.IFuseRs1 = u1;  hz1.IFuseRs2 = u2;
        hz1.IDrd = rd;    hz1.IDmemRead = mrd; hz1.IDvalid = idv;
        hz1.mem_ready = mrdy; hz1.flush = fl;
        hz3.IFrs1 = rs1;  hz3.IFrs2 = rs2;  hz3.IFuseRs1 = u1;  hz3.IFuseRs2 = u2;
        hz3.IDrd = rd;    hz3.IDmemRead = mrd; hz3.IDvalid = idv;
        hz3.mem_ready = mrdy; hz3.flush = fl;
        #1;
        hit_id = idv && mrd && (rd != 5'd0) && ((u1 && rd == rs1) || (u2 && rd == rs2));
        for (int i = 0; i < 2; i++) begin
            exp_stall[i] = !r_rst && !fl &&
                           (hit_id || (u1 && pending(i, rs1)) || (u2 && pending(i, rs2)));
            exp_busy = 1'b0;
            for (int r = 1; r < 32; r++) begin
                if (ready_at[i][r] > tick) exp_busy = 1'b1;
            end
            exp_busy = exp_busy && !r_rst;
            if (i == 0) begin
                check_eq("l1_stall",  32'(hz1.stall),       32'(exp_stall[i]));
                check_eq("l1_freeze", 32'(hz1.freeze),      32'(!mrdy && !r_rst));
                check_eq("l1_busy",   32'(hz1.busy_any),    32'(exp_busy));
                check_eq("l1_count",  32'(hz1.stall_count), 32'(scount[i]));
            end else begin
                check_eq("l3_stall",  32'(hz3.stall),       32'(exp_stall[i]));
                check_eq("l3_freeze", 32'(hz3.freeze),      32'(!mrdy && !r_rst));
                check_eq("l3_busy",   32'(hz3.busy_any),    32'(exp_busy));
                check_eq("l3_count",  32'(hz3.stall_count), 32'(scount[i]));
            end
        end
        // Advance the reference across the coming edge.
        for (int i = 0; i < 2; i++) begin
            if (r_rst) begin
                for (int r = 0; r < 32; r++) ready_at[i][r] = 0;
                scount[i] = 0;
            end else if (mrdy) begin
                if (exp_stall[i] && scount[i] < smax[i]) scount[i] = scount[i] + 1;
                if (idv && mrd && rd != 5'd0) ready_at[i][rd] = tick + lat[i];
            end
        end
        if (!r_rst && mrdy) tick = tick + 1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 4))
            0: return 5'd0;
            1: return 5'd5;
            2: return 5'd7;
            3: return 5'd9;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    initial begin
        tick = 0;
        for (int i = 0; i < 2; i++) begin
            scount[i] = 0;
            for (int r = 0; r < 32; r++) ready_at[i][r] = 0;
        end
        rst = 1'b1;
        hz1.IFrs1 = '0; hz1.IFrs2 = '0; hz1.IFuseRs1 = 1'b0; hz1.IFuseRs2 = 1'b0;
        hz1.IDrd = '0; hz1.IDmemRead = 1'b0; hz1.IDvalid = 1'b0;
        hz1.mem_ready = 1'b1; hz1.flush = 1'b0;
        hz3.IFrs1 = '0; hz3.IFrs2 = '0; hz3.IFuseRs1 = 1'b0; hz3.IFuseRs2 = 1'b0;
        hz3.IDrd = '0; hz3.IDmemRead = 1'b0; hz3.IDvalid = 1'b0;
        hz3.mem_ready = 1'b1; hz3.flush = 1'b0;
        @(posedge clk);
        #1;
        //   rst rs1   rs2   u1    u2    rd    mrd   idv   rdy   fl
        cyc(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        // Load x5/x7 with a dependent reader right behind, then bubbles.
        cyc(1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++)
            cyc(1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        // Load x7, one independent slot, then a reader with and without rs1 use.
        cyc(1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 5'd7, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++)
            cyc(1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        // Memory stall in the middle of an interlock.
        cyc(1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++)
            cyc(1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++)
            cyc(1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        // x0 never interlocks; back-to-back loads to x9; flush masks a live hit.
        cyc(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 5'd0, 5'd9, 1'b0, 1'b1, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 5'd0, 5'd9, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        // Reset mid-countdown.
        cyc(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        // Long random run; stall counts saturate in the 4-bit instance.
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 99) < 2),
                pick_reg(), pick_reg(),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) != 0),
                pick_reg(),
                ($urandom_range(0, 1) != 0), ($urandom_range(0, 4) != 0),
                ($urandom_range(0, 9) > 1), ($urandom_range(0, 9) == 0));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
